rf_wb_ctrl: RTL and testbench



---
 rtl/wisc_pkg.sv | 18 +
 rtl/rf_wb_ctrl_wb_queue.sv | 68 ++++++
 rtl/rf_wb_ctrl.sv | 126 ++++++++++++
 tb/tb_rf_wb_ctrl.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared types for the writeback / register-file slice.
package wisc_pkg;

  localparam int REG_AW = 4;
  localparam int DATA_W = 16;

  // One pending register-file write.
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Number of entries offered to the write queue in one cycle (0..2).
  function automatic logic [1:0] push_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/rf_wb_ctrl_wb_queue.sv
// In-order write queue: circular buffer taking up to two entries per cycle
// (entry a older than entry b) and retiring the head entry every non-empty cycle.
module wb_queue
  import wisc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_a,
  input  wb_entry_t                ent_a,
  input  logic                     push_b,
  input  wb_entry_t                ent_b,
  output logic [$clog2(DEPTH)-1:0] head,
  output logic [$clog2(DEPTH):0]   count,
  output wb_entry_t                ent_q [DEPTH],
  output logic [DEPTH-1:0]         live
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] tail;
  logic [PW-1:0] slot_b;
  logic [PW-1:0] age;
  logic [1:0]    n_push;
  logic          pop;

  // Push/pop bookkeeping: entry b lands after entry a when both are present.
  always_comb begin
    n_push = push_count(push_a, push_b);
    pop    = (count != '0);
    slot_b = push_a ? tail + PW'(1) : tail;
  end

  // Pointer and occupancy registers; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + PW'(n_push);
      head  <= head + PW'(pop);
      count <= count + CW'(n_push) - CW'(pop);
    end
  end

  // Entry storage; contents are only observed through live/count, so no reset.
  always_ff @(posedge clk) begin
    if (push_a) mem[tail]   <= ent_a;
    if (push_b) mem[slot_b] <= ent_b;
  end

  assign ent_q = mem;

  // Slot k is live when its distance from head is below the occupancy.
  always_comb begin
    live = '0;
    age  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      age     = PW'(k) - head;
      live[k] = ({1'b0, age} < count);
    end
  end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Writeback controller: merges memory- and ALU-stage results into an in-order
// write queue, drives the register-file write port from the queue head and
// offers youngest-wins bypass data for the two read ports.
module rf_wb_ctrl
  import wisc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_vld,
  input  logic [AW-1:0] mem_dst_addr,
  input  logic [DW-1:0] mem_data,
  input  logic          alu_vld,
  input  logic [AW-1:0] alu_dst_addr,
  input  logic [DW-1:0] alu_data,
  output logic          wb_rdy,
  input  logic [AW-1:0] p0_addr,
  input  logic [AW-1:0] p1_addr,
  output logic          byp0_hit,
  output logic [DW-1:0] byp0_data,
  output logic          byp1_hit,
  output logic [DW-1:0] byp1_data,
  output logic [AW-1:0] dst_addr,
  output logic [DW-1:0] dst,
  output logic          we,
  input  logic          hlt,
  output logic          drained,
  output logic          ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic             mem_ok;
  logic             alu_ok;
  logic             push_req;
  logic             push_a;
  logic             push_b;
  wb_entry_t        ent_a;
  wb_entry_t        ent_b;
  wb_entry_t        ent_q [DEPTH];
  wb_entry_t        head_ent;
  logic [PW-1:0]    head;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] live;
  logic [PW-1:0]    idx;

  // R0 writes are dropped; a cycle with any surviving result while not ready
  // is discarded as a whole.
  always_comb begin
    mem_ok     = mem_vld && (mem_dst_addr != '0);
    alu_ok     = alu_vld && (alu_dst_addr != '0);
    push_req   = mem_ok || alu_ok;
    wb_rdy     = (count <= CW'(DEPTH - 2));
    push_a     = mem_ok && wb_rdy;
    push_b     = alu_ok && wb_rdy;
    ent_a.addr = mem_dst_addr;
    ent_a.data = mem_data;
    ent_b.addr = alu_dst_addr;
    ent_b.data = alu_data;
  end

  wb_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk    (clk),
    .rst    (rst),
    .push_a (push_a),
    .ent_a  (ent_a),
    .push_b (push_b),
    .ent_b  (ent_b),
    .head   (head),
    .count  (count),
    .ent_q  (ent_q),
    .live   (live)
  );

  // Sticky overflow flag and registered drain indication.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf     <= 1'b0;
      drained <= 1'b0;
    end else begin
      if (push_req && !wb_rdy) ovf <= 1'b1;
      drained <= hlt && (count == '0);
    end
  end

  // RF write port straight from the head entry, zeroed when idle.
  always_comb begin
    head_ent = ent_q[head];
    we       = (count != '0);
    dst_addr = '0;
    dst      = '0;
    if (we) begin
      dst_addr = head_ent.addr;
      dst      = head_ent.data;
    end
  end

  // Bypass search walks from head towards tail so the youngest match is kept.
  always_comb begin
    byp0_hit  = 1'b0;
    byp0_data = '0;
    byp1_hit  = 1'b0;
    byp1_data = '0;
    idx       = head;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (live[idx]) begin
        if ((p0_addr != '0) && (ent_q[idx].addr == p0_addr)) begin
          byp0_hit  = 1'b1;
          byp0_data = ent_q[idx].data;
        end
        if ((p1_addr != '0) && (ent_q[idx].addr == p1_addr)) begin
          byp1_hit  = 1'b1;
          byp1_data = ent_q[idx].data;
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Self-checking bench for rf_wb_ctrl: scoreboard of expected RF writes plus
// per-scenario directed checks.
module tb_rf_wb_ctrl;

  localparam int DEPTH = 4;
  localparam int AW    = 4;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_vld;
  logic [AW-1:0] mem_dst_addr;
  logic [DW-1:0] mem_data;
  logic          alu_vld;
  logic [AW-1:0] alu_dst_addr;
  logic [DW-1:0] alu_data;
  logic          wb_rdy;
  logic [AW-1:0] p0_addr;
  logic [AW-1:0] p1_addr;
  logic          byp0_hit;
  logic [DW-1:0] byp0_data;
  logic          byp1_hit;
  logic [DW-1:0] byp1_data;
  logic [AW-1:0] dst_addr;
  logic [DW-1:0] dst;
  logic          we;
  logic          hlt;
  logic          drained;
  logic          ovf;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   m_cnt     = 0;
  bit   m_ovf     = 1'b0;
  bit   m_drained = 1'b0;
  bit   started   = 1'b0;
  int   checks    = 0;
  int   errors    = 0;

  always #5 clk = ~clk;

  rf_wb_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_vld      (mem_vld),
    .mem_dst_addr (mem_dst_addr),
    .mem_data     (mem_data),
    .alu_vld      (alu_vld),
    .alu_dst_addr (alu_dst_addr),
    .alu_data     (alu_data),
    .wb_rdy       (wb_rdy),
    .p0_addr      (p0_addr),
    .p1_addr      (p1_addr),
    .byp0_hit     (byp0_hit),
    .byp0_data    (byp0_data),
    .byp1_hit     (byp1_hit),
    .byp1_data    (byp1_data),
    .dst_addr     (dst_addr),
    .dst          (dst),
    .we           (we),
    .hlt          (hlt),
    .drained      (drained),
    .ovf          (ovf)
  );

  // Reference model: accepted results are pushed to the scoreboard at the edge.
  initial begin
    bit mok;
    bit aok;
    int n;
    forever begin
      @(posedge clk);
      if (rst) begin
        sb.delete();
        m_cnt     = 0;
        m_ovf     = 1'b0;
        m_drained = 1'b0;
      end else begin
        mok       = mem_vld && (mem_dst_addr != 0);
        aok       = alu_vld && (alu_dst_addr != 0);
        n         = 0;
        m_drained = hlt && (m_cnt == 0);
        if ((mok || aok) && (m_cnt > DEPTH - 2)) begin
          m_ovf = 1'b1;
        end else begin
          if (mok) begin sb.push_back(exp_t'{mem_dst_addr, mem_data}); n++; end
          if (aok) begin sb.push_back(exp_t'{alu_dst_addr, alu_data}); n++; end
        end
        m_cnt = m_cnt + n - ((m_cnt > 0) ? 1 : 0);
      end
      started = 1'b1;
    end
  end

  // Scoreboard monitor: mid-cycle comparison of all outputs against the model.
  initial begin
    exp_t          e;
    bit            eh0, eh1, erdy;
    logic [DW-1:0] ed0, ed1;
    forever begin
      @(negedge clk);
      if (started) begin
        eh0 = 1'b0; ed0 = '0; eh1 = 1'b0; ed1 = '0;
        foreach (sb[i]) begin
          if (p0_addr != 0 && sb[i].addr == p0_addr) begin eh0 = 1'b1; ed0 = sb[i].data; end
          if (p1_addr != 0 && sb[i].addr == p1_addr) begin eh1 = 1'b1; ed1 = sb[i].data; end
        end
        checks++;
        if (byp0_hit !== eh0 || byp0_data !== ed0) begin
          errors++;
          $display("FAIL sb_byp0 @%0t: got hit=%0b data=%h, expected hit=%0b data=%h", $time, byp0_hit, byp0_data, eh0, ed0);
        end
        checks++;
        if (byp1_hit !== eh1 || byp1_data !== ed1) begin
          errors++;
          $display("FAIL sb_byp1 @%0t: got hit=%0b data=%h, expected hit=%0b data=%h", $time, byp1_hit, byp1_data, eh1, ed1);
        end
        erdy = (m_cnt <= DEPTH - 2);
        checks++;
        if (wb_rdy !== erdy) begin
          errors++;
          $display("FAIL sb_wb_rdy @%0t: got %0b, expected %0b", $time, wb_rdy, erdy);
        end
        checks++;
        if (ovf !== m_ovf) begin
          errors++;
          $display("FAIL sb_ovf @%0t: got %0b, expected %0b", $time, ovf, m_ovf);
        end
        checks++;
        if (drained !== m_drained) begin
          errors++;
          $display("FAIL sb_drained @%0t: got %0b, expected %0b", $time, drained, m_drained);
        end
        if (m_cnt > 0 && sb.size() > 0) begin
          e = sb.pop_front();
          checks++;
          if (we !== 1'b1 || dst_addr !== e.addr || dst !== e.data) begin
            errors++;
            $display("FAIL sb_rf_write @%0t: got we=%0b addr=%0d data=%h, expected we=1 addr=%0d data=%h", $time, we, dst_addr, dst, e.addr, e.data);
          end
        end else begin
          checks++;
          if (we !== 1'b0 || dst_addr !== '0 || dst !== '0) begin
            errors++;
            $display("FAIL sb_rf_idle @%0t: got we=%0b addr=%0d data=%h, expected we=0 addr=0 data=0", $time, we, dst_addr, dst);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_vld      = 1'b0;
    mem_dst_addr = '0;
    mem_data     = '0;
    alu_vld      = 1'b0;
    alu_dst_addr = '0;
    alu_data     = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_vld = 1'b1; mem_dst_addr = 4'd4; mem_data = 16'h4444;
    alu_vld = 1'b1; alu_dst_addr = 4'd3; alu_data = 16'h5555;
    p0_addr = 4'd3;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (we !== 1'b0 || wb_rdy !== 1'b1 || ovf !== 1'b0 || byp0_hit !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: got we=%0b wb_rdy=%0b ovf=%0b hit=%0b, expected 0 1 0 0", we, wb_rdy, ovf, byp0_hit);
      end
    end
    rst = 1'b0;
    idle();
    tick();
    checks++;
    if (we !== 1'b0 || dst_addr !== '0 || dst !== '0 || drained !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got we=%0b addr=%0d data=%h drained=%0b, expected 0 0 0000 0", we, dst_addr, dst, drained);
    end
    p0_addr = '0;
    tick();
  endtask

  task automatic test_single();
    alu_vld = 1'b1; alu_dst_addr = 4'd3; alu_data = 16'h1234;
    tick();
    idle();
    checks++;
    if (we !== 1'b1 || dst_addr !== 4'd3 || dst !== 16'h1234) begin
      errors++;
      $display("FAIL single_write: got we=%0b addr=%0d data=%h, expected 1 3 1234", we, dst_addr, dst);
    end
    tick();
    checks++;
    if (we !== 1'b0) begin
      errors++;
      $display("FAIL single_after: got we=%0b, expected 0", we);
    end
  endtask

  task automatic test_dual();
    mem_vld = 1'b1; mem_dst_addr = 4'd5; mem_data = 16'hAAAA;
    alu_vld = 1'b1; alu_dst_addr = 4'd5; alu_data = 16'hBBBB;
    p0_addr = 4'd5; p1_addr = 4'd6;
    tick();
    idle();
    checks++;
    if (we !== 1'b1 || dst_addr !== 4'd5 || dst !== 16'hAAAA) begin
      errors++;
      $display("FAIL dual_first: got we=%0b addr=%0d data=%h, expected 1 5 aaaa", we, dst_addr, dst);
    end
    checks++;
    if (byp0_hit !== 1'b1 || byp0_data !== 16'hBBBB || byp1_hit !== 1'b0) begin
      errors++;
      $display("FAIL dual_byp_both: got hit0=%0b data0=%h hit1=%0b, expected 1 bbbb 0", byp0_hit, byp0_data, byp1_hit);
    end
    tick();
    checks++;
    if (we !== 1'b1 || dst !== 16'hBBBB || byp0_hit !== 1'b1 || byp0_data !== 16'hBBBB) begin
      errors++;
      $display("FAIL dual_second: got we=%0b data=%h hit0=%0b data0=%h, expected 1 bbbb 1 bbbb", we, dst, byp0_hit, byp0_data);
    end
    tick();
    checks++;
    if (we !== 1'b0 || byp0_hit !== 1'b0) begin
      errors++;
      $display("FAIL dual_empty: got we=%0b hit0=%0b, expected 0 0", we, byp0_hit);
    end
    p0_addr = '0; p1_addr = '0;
  endtask

  task automatic test_r0_filter();
    alu_vld = 1'b1; alu_dst_addr = 4'd0; alu_data = 16'hFFFF;
    p0_addr = 4'd0;
    tick();
    idle();
    checks++;
    if (we !== 1'b0 || ovf !== 1'b0 || byp0_hit !== 1'b0 || byp0_data !== '0 || wb_rdy !== 1'b1) begin
      errors++;
      $display("FAIL r0_filter: got we=%0b ovf=%0b hit=%0b data=%h rdy=%0b, expected 0 0 0 0000 1", we, ovf, byp0_hit, byp0_data, wb_rdy);
    end
    tick();
  endtask

  task automatic test_halt_drain();
    mem_vld = 1'b1; mem_dst_addr = 4'd7; mem_data = 16'h7777;
    alu_vld = 1'b1; alu_dst_addr = 4'd8; alu_data = 16'h8888;
    tick();
    mem_dst_addr = 4'd9;  mem_data = 16'h9999;
    alu_dst_addr = 4'd10; alu_data = 16'hA0A0;
    tick();
    idle();
    hlt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (drained !== 1'b0 || we !== ((i < 2) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL halt_draining[%0d]: got drained=%0b we=%0b, expected drained=0 we=%0b", i, drained, we, (i < 2));
      end
    end
    tick();
    checks++;
    if (drained !== 1'b1) begin
      errors++;
      $display("FAIL halt_drained: got %0b, expected 1", drained);
    end
    hlt = 1'b0;
    tick();
    checks++;
    if (drained !== 1'b0) begin
      errors++;
      $display("FAIL halt_release: got %0b, expected 0", drained);
    end
  endtask

  task automatic test_full_overflow();
    logic [DW-1:0] exp_d [4];
    int nwr;
    exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h3333; exp_d[3] = 16'h4444;
    nwr = 0;
    mem_vld = 1'b1; mem_dst_addr = 4'd1; mem_data = 16'h1111;
    alu_vld = 1'b1; alu_dst_addr = 4'd2; alu_data = 16'h2222;
    tick();
    checks++;
    if (wb_rdy !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL full_count2: got rdy=%0b ovf=%0b, expected 1 0", wb_rdy, ovf);
    end
    if (we === 1'b1) begin
      checks++;
      if (dst !== exp_d[nwr]) begin errors++; $display("FAIL full_order[%0d]: got %h, expected %h", nwr, dst, exp_d[nwr]); end
      nwr++;
    end
    mem_dst_addr = 4'd3; mem_data = 16'h3333;
    alu_dst_addr = 4'd4; alu_data = 16'h4444;
    tick();
    checks++;
    if (wb_rdy !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL full_count3: got rdy=%0b ovf=%0b, expected 0 0", wb_rdy, ovf);
    end
    if (we === 1'b1) begin
      checks++;
      if (dst !== exp_d[nwr]) begin errors++; $display("FAIL full_order[%0d]: got %h, expected %h", nwr, dst, exp_d[nwr]); end
      nwr++;
    end
    mem_dst_addr = 4'd5; mem_data = 16'h5555;
    alu_dst_addr = 4'd6; alu_data = 16'h6666;
    tick();
    idle();
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL full_ovf: got %0b, expected 1", ovf);
    end
    for (int i = 0; i < 4; i++) begin
      if (we === 1'b1) begin
        checks++;
        if (nwr >= 4 || dst !== exp_d[nwr]) begin
          errors++;
          $display("FAIL full_order[%0d]: got %h, expected only 4 writes 1111..4444", nwr, dst);
        end
        nwr++;
      end
      tick();
    end
    checks++;
    if (nwr != 4) begin
      errors++;
      $display("FAIL full_write_count: got %0d, expected 4", nwr);
    end
  endtask

  task automatic test_back_to_back();
    bit done;
    for (int i = 0; i < 60; i++) begin
      mem_vld      = 1'($urandom_range(0, 1));
      mem_dst_addr = 4'($urandom_range(0, 7));
      mem_data     = 16'($urandom);
      alu_vld      = 1'($urandom_range(0, 1));
      alu_dst_addr = 4'($urandom_range(0, 7));
      alu_data     = 16'($urandom);
      p0_addr      = 4'($urandom_range(0, 7));
      p1_addr      = 4'($urandom_range(0, 7));
      hlt          = ($urandom_range(0, 7) == 0);
      tick();
    end
    idle();
    hlt = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      tick();
      if (we === 1'b0) done = 1'b1;
    end
    checks++;
    if (we !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got we=%0b after 8 idle cycles, expected 0", we);
    end
    p0_addr = '0; p1_addr = '0;
  endtask

  task automatic test_reset_mid();
    mem_vld = 1'b1; mem_dst_addr = 4'd1; mem_data = 16'hC001;
    alu_vld = 1'b1; alu_dst_addr = 4'd2; alu_data = 16'hC002;
    tick();
    idle();
    checks++;
    if (we !== 1'b1 || dst !== 16'hC001) begin
      errors++;
      $display("FAIL mid_pre: got we=%0b data=%h, expected 1 c001", we, dst);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (we !== 1'b0 || ovf !== 1'b0 || wb_rdy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got we=%0b ovf=%0b rdy=%0b, expected 0 0 1", we, ovf, wb_rdy);
    end
    tick();
    checks++;
    if (we !== 1'b0) begin
      errors++;
      $display("FAIL mid_after: got we=%0b, expected 0", we);
    end
  endtask

  initial begin
    rst = 1'b1;
    hlt = 1'b0;
    p0_addr = '0;
    p1_addr = '0;
    idle();
    test_reset();
    test_single();
    test_dual();
    test_r0_filter();
    test_halt_drain();
    test_full_overflow();
    test_back_to_back();
    test_reset_mid();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
